regfile_wr_demux_8x16: RTL and testbench

- 8-entry register file for the unpipelined WiscSP13 datapath.
- The upstream 4:1 3-bit destination-select path picks which register to write. This block is the receiving end: it decodes that 3-bit register ID into one-hot write enables, stores the data, and serves two combinational read ports.
- Each register has a "written since reset" valid bit, so downstream logic can tell a real value from a reset value.

---
 rtl/regfile_wr_demux_8x16.sv | 116 +++++++++++
 tb/tb_regfile_wr_demux_8x16.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_demux_8x16.sv
// ---------------------------------------------------------------------------------------------
// regfile_wr_demux_8x16
//
// Eight-entry register file for the unpipelined WiscSP13 datapath. The 3-bit destination ID
// from the upstream destination-select mux is decoded into one-hot write enables. The selected
// register captures wr_data on the rising edge. Two combinational read ports return the stored
// data and a per-register "written since reset" valid bit. A saturating 8-bit counter tracks
// the number of accepted writes.
//
// Build option:
//   RF_BYPASS_EN  When defined, a read port that addresses the register being written in the
//                 current cycle returns wr_data with valid = 1 in that same cycle. Bypass is
//                 suppressed while rst_n is low. When undefined, reads return stored contents
//                 only.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   wr_en      in   write request this cycle
//   wr_reg     in   [2:0] destination register ID
//   wr_data    in   [DATA_W-1:0] write data
//   rd_reg1/2  in   [2:0] read port register IDs
//   rd_data1/2 out  [DATA_W-1:0] read data
//   rd_vld1/2  out  valid bit of the addressed register
//   wr_onehot  out  [7:0] decoded write enables (independent of rst_n)
//   wr_cnt     out  [7:0] saturating count of accepted writes since reset
// ---------------------------------------------------------------------------------------------
module regfile_wr_demux_8x16 #(
    parameter int unsigned          DATA_W    = 16,
    parameter logic [DATA_W-1:0]    RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [2:0]        wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        rd_reg1,
    input  logic [2:0]        rd_reg2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_vld1,
    output logic              rd_vld2,
    output logic [7:0]        wr_onehot,
    output logic [7:0]        wr_cnt
);

    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];
    logic [7:0]        vld_q;
    logic [7:0]        vld_d;
    logic [7:0]        wr_cnt_q;
    logic [7:0]        wr_cnt_d;

    // Write decode: at most one bit set, purely a function of wr_en and wr_reg.
    always_comb begin
        wr_onehot = 8'h00;
        if (wr_en) begin
            wr_onehot = 8'b1 << wr_reg;
        end
    end

    // Next-state: only the decoded register and its valid bit change.
    always_comb begin
        vld_d    = vld_q;
        wr_cnt_d = wr_cnt_q;
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_onehot[i]) begin
                regs_d[i] = wr_data;
                vld_d[i]  = 1'b1;
            end
        end
        if (wr_en && (wr_cnt_q != 8'hFF)) begin
            wr_cnt_d = wr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            vld_q    <= 8'h00;
            wr_cnt_q <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            vld_q    <= vld_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign wr_cnt = wr_cnt_q;

    // Read ports. With bypass, an in-flight write to the addressed register is forwarded.
    always_comb begin
        rd_data1 = regs_q[rd_reg1];
        rd_vld1  = vld_q[rd_reg1];
        rd_data2 = regs_q[rd_reg2];
        rd_vld2  = vld_q[rd_reg2];
`ifdef RF_BYPASS_EN
        // Gate on rst_n so reset values are visible immediately, even mid-write.
        if (rst_n && wr_en && (rd_reg1 == wr_reg)) begin
            rd_data1 = wr_data;
            rd_vld1  = 1'b1;
        end
        if (rst_n && wr_en && (rd_reg2 == wr_reg)) begin
            rd_data2 = wr_data;
            rd_vld2  = 1'b1;
        end
`else
`endif
    end

endmodule

// File: tb/tb_regfile_wr_demux_8x16.sv
module tb_regfile_wr_demux_8x16;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_reg;
    logic [15:0] wr_data;
    logic [2:0]  rd_reg1;
    logic [2:0]  rd_reg2;
    logic [15:0] rd_data1;
    logic [15:0] rd_data2;
    logic        rd_vld1;
    logic        rd_vld2;
    logic [7:0]  wr_onehot;
    logic [7:0]  wr_cnt;

    int checks;
    int failures;
    int model_cnt;

    regfile_wr_demux_8x16 #(
        .DATA_W    (16),
        .RESET_VAL (16'h0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .rd_reg1   (rd_reg1),
        .rd_reg2   (rd_reg2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .rd_vld1   (rd_vld1),
        .rd_vld2   (rd_vld2),
        .wr_onehot (wr_onehot),
        .wr_cnt    (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One write: inputs set on the falling edge, wr_en dropped just after the rising edge.
    task automatic do_write(input logic [2:0] r, input logic [15:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_reg  = r;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        model_cnt = (model_cnt == 255) ? 255 : model_cnt + 1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #17;
        checks++;
        if (wr_cnt !== 8'h00 || rd_vld1 !== 1'b0 || rd_vld2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: cnt=%h vld1=%b vld2=%b, want cnt=00 vld=0",
                     wr_cnt, rd_vld1, rd_vld2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            rd_reg1 = 3'(i);
            rd_reg2 = 3'(7 - i);
            #1;
            checks++;
            if (rd_data1 !== 16'h0000 || rd_vld1 !== 1'b0 ||
                rd_data2 !== 16'h0000 || rd_vld2 !== 1'b0) begin
                failures++;
                $display("FAIL reset_read id=%0d: d1=%h v1=%b d2=%h v2=%b, want 0000/0",
                         i, rd_data1, rd_vld1, rd_data2, rd_vld2);
            end
        end
    endtask

    task automatic test_write_all;
        logic [7:0] exp_oh;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_reg  = 3'(i);
            wr_data = 16'hA000 + 16'(i);
            #1;
            exp_oh = 8'h01 << i;
            checks++;
            if (wr_onehot !== exp_oh) begin
                failures++;
                $display("FAIL onehot id=%0d: got %h want %h", i, wr_onehot, exp_oh);
            end
            @(posedge clk);
            #1;
            wr_en = 1'b0;
            model_cnt++;
        end
        for (int i = 0; i < 8; i++) begin
            rd_reg1 = 3'(i);
            #1;
            checks++;
            if (rd_data1 !== 16'hA000 + 16'(i) || rd_vld1 !== 1'b1) begin
                failures++;
                $display("FAIL write_all_read id=%0d: got %h/%b want %h/1",
                         i, rd_data1, rd_vld1, 16'hA000 + 16'(i));
            end
        end
        checks++;
        if (wr_cnt !== 8'd8) begin
            failures++;
            $display("FAIL write_all_cnt: got %0d want 8", wr_cnt);
        end
    endtask

    task automatic test_same_cycle;
        logic [15:0] exp_now;
        do_write(3'd3, 16'h1111);
        @(negedge clk);
        rd_reg1 = 3'd3;
        wr_en   = 1'b1;
        wr_reg  = 3'd3;
        wr_data = 16'h2222;
        #1;
`ifdef RF_BYPASS_EN
        exp_now = 16'h2222;
`else
        exp_now = 16'h1111;
`endif
        checks++;
        if (rd_data1 !== exp_now || rd_vld1 !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_read: got %h/%b want %h/1", rd_data1, rd_vld1, exp_now);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        model_cnt++;
        checks++;
        if (rd_data1 !== 16'h2222) begin
            failures++;
            $display("FAIL same_cycle_next: got %h want 2222", rd_data1);
        end
    endtask

    task automatic test_dual_idle;
        do_write(3'd5, 16'hBEEF);
        @(negedge clk);
        rd_reg1 = 3'd5;
        rd_reg2 = 3'd5;
        wr_en   = 1'b0;
        wr_reg  = 3'd5;
        wr_data = 16'h0000;
        #1;
        checks++;
        if (rd_data1 !== 16'hBEEF || rd_data2 !== 16'hBEEF || wr_onehot !== 8'h00) begin
            failures++;
            $display("FAIL dual_read: d1=%h d2=%h oh=%h want BEEF BEEF 00",
                     rd_data1, rd_data2, wr_onehot);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd_data1 !== 16'hBEEF || rd_data2 !== 16'hBEEF || rd_vld2 !== 1'b1 ||
            wr_cnt !== 8'(model_cnt)) begin
            failures++;
            $display("FAIL idle_no_change: d1=%h d2=%h v2=%b cnt=%0d want BEEF BEEF 1 %0d",
                     rd_data1, rd_data2, rd_vld2, wr_cnt, model_cnt);
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 300; i++) begin
            do_write(3'(i), 16'(16'h4000 + i));
            checks++;
            if (wr_cnt !== 8'(model_cnt)) begin
                failures++;
                $display("FAIL sat_cnt write=%0d: got %0d want %0d", i, wr_cnt, model_cnt);
            end
        end
        checks++;
        if (wr_cnt !== 8'hFF) begin
            failures++;
            $display("FAIL sat_final: got %h want FF", wr_cnt);
        end
    endtask

    task automatic test_reset_mid_op;
        rd_reg1 = 3'd2;
        #1;
        checks++;
        if (rd_vld1 !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_vld: got %b want 1", rd_vld1);
        end
        @(negedge clk);
        wr_en   = 1'b1;
        wr_reg  = 3'd2;
        wr_data = 16'h5555;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data1 !== 16'h0000 || rd_vld1 !== 1'b0 || wr_cnt !== 8'h00 ||
            wr_onehot !== 8'h04) begin
            failures++;
            $display("FAIL async_reset: d1=%h v1=%b cnt=%h oh=%h want 0000 0 00 04",
                     rd_data1, rd_vld1, wr_cnt, wr_onehot);
        end
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        model_cnt = 0;
        #1;
        checks++;
        if (rd_data1 !== 16'h0000 || rd_vld1 !== 1'b0 || wr_cnt !== 8'h00) begin
            failures++;
            $display("FAIL reset_wins: d1=%h v1=%b cnt=%h want 0000 0 00",
                     rd_data1, rd_vld1, wr_cnt);
        end
        do_write(3'd2, 16'h1234);
        checks++;
        if (rd_data1 !== 16'h1234 || rd_vld1 !== 1'b1 || wr_cnt !== 8'h01) begin
            failures++;
            $display("FAIL first_write_after_reset: d1=%h v1=%b cnt=%h want 1234 1 01",
                     rd_data1, rd_vld1, wr_cnt);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        model_cnt = 0;
        rst_n     = 1'b1;
        wr_en     = 1'b0;
        wr_reg    = 3'd0;
        wr_data   = 16'h0000;
        rd_reg1   = 3'd0;
        rd_reg2   = 3'd0;
        test_reset();
        test_write_all();
        test_same_cycle();
        test_dual_idle();
        test_saturation();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
